// File: rtl/net_ingress_arbiter_pkg.sv
// Shared constants and state encoding for the network ingress arbiter.
// Byte offsets count from the first byte of the Ethernet frame.
package net_pkg;

   localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  ETH_TYPE_OFFSET = 8'd12;

   typedef enum logic {
      IDLE = 1'b0,
      FWD  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/net_ingress_arbiter_if.sv
// Ingress/egress byte-stream bundle between the MAC ports and the arbiter.
// The slave view belongs to the arbiter; the master view belongs to whatever drives it.
interface net_ingress_arbiter_if #(
   parameter int NUM_PORTS = 4
);
   localparam int PW = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]   IN_VALID;
   logic [8*NUM_PORTS-1:0] IN_DATA;
   logic [NUM_PORTS-1:0]   IN_LAST;
   logic [NUM_PORTS-1:0]   IN_READY;
   logic                   OUT_VALID;
   logic [7:0]             OUT_DATA;
   logic                   OUT_LAST;
   logic                   OUT_READY;
   logic [PW-1:0]          OUT_PORT;
   logic                   IS_IP;
   logic                   IS_IP_VALID;

   modport master (
      output IN_VALID, IN_DATA, IN_LAST, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, OUT_PORT, IS_IP, IS_IP_VALID
   );

   modport slave (
      input  IN_VALID, IN_DATA, IN_LAST, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, OUT_PORT, IS_IP, IS_IP_VALID
   );

endinterface

// File: rtl/net_ingress_arbiter_rr.sv
// Stateless round-robin pick: the first requester found searching upward from
// rr_ptr+1, wrapping at NUM_PORTS.
module net_rr_arbiter #(
   parameter  int NUM_PORTS = 4,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        rr_ptr,
   output logic                 gnt_any,
   output logic [PW-1:0]        gnt_idx
);

   logic [PW-1:0] cand;

   // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/net_ingress_arbiter.sv
// Frame-locked round-robin arbiter: one ingress port owns the output for a whole
// frame while its EtherType is classified on the fly.
module net_ingress_arbiter
   import net_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic                 CLK,
   input  logic                 RST,
   net_ingress_arbiter_if.slave bus
);

   localparam logic [7:0] ETH_TYPE_END = ETH_TYPE_OFFSET + 8'd1;

   arb_state_e    state_q, state_d;
   logic [PW-1:0] grant_q, rr_ptr_q, arb_idx;
   logic          arb_any;
   logic [7:0]    byte_cnt_q, type_hi_q;
   logic          is_ip_q, is_ip_valid_q;
   logic          sel_valid, sel_last, beat;
   logic [7:0]    sel_data;

   net_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
      .req     (bus.IN_VALID),
      .rr_ptr  (rr_ptr_q),
      .gnt_any (arb_any),
      .gnt_idx (arb_idx)
   );

   assign sel_valid = bus.IN_VALID[grant_q];
   assign sel_last  = bus.IN_LAST[grant_q];
   assign sel_data  = bus.IN_DATA[{grant_q, 3'b000} +: 8];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Zero-latency passthrough of the granted port while forwarding.
   always_comb begin
      state_d       = state_q;
      bus.IN_READY  = '0;
      bus.OUT_VALID = 1'b0;
      bus.OUT_DATA  = '0;
      bus.OUT_LAST  = 1'b0;
      beat          = 1'b0;
      case (state_q)
         IDLE: if (arb_any) state_d = FWD;
         FWD: begin
            bus.OUT_VALID         = sel_valid;
            bus.OUT_DATA          = sel_data;
            bus.OUT_LAST          = sel_last;
            bus.IN_READY[grant_q] = bus.OUT_READY;
            beat                  = sel_valid && bus.OUT_READY;
            if (beat && sel_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         grant_q       <= '0;
         rr_ptr_q      <= PW'(NUM_PORTS - 1);
         byte_cnt_q    <= '0;
         type_hi_q     <= '0;
         is_ip_q       <= 1'b0;
         is_ip_valid_q <= 1'b0;
      end else begin
         is_ip_valid_q <= 1'b0;
         // IS_IP clears only when the next frame is granted, so it stays readable past frame end.
         if (state_q == IDLE && arb_any) begin
            grant_q    <= arb_idx;
            byte_cnt_q <= '0;
            is_ip_q    <= 1'b0;
         end
         if (beat) begin
            if (byte_cnt_q != 8'hFF) byte_cnt_q <= byte_cnt_q + 8'd1;
            if (byte_cnt_q == ETH_TYPE_OFFSET) type_hi_q <= sel_data;
            if (byte_cnt_q == ETH_TYPE_END) begin
               is_ip_q       <= ({type_hi_q, sel_data} == ETHERTYPE_IPV4);
               is_ip_valid_q <= 1'b1;
            end else if (sel_last && byte_cnt_q < ETH_TYPE_END) begin
               is_ip_valid_q <= 1'b1;
            end
            if (sel_last) rr_ptr_q <= grant_q;
         end
      end
   end

   assign bus.OUT_PORT    = grant_q;
   assign bus.IS_IP       = is_ip_q;
   assign bus.IS_IP_VALID = is_ip_valid_q;

endmodule

// File: tb/tb_net_ingress_arbiter.sv
// Scoreboard bench for net_ingress_arbiter: per-port byte/classification queues,
// expected grant order, and classification pulse timing checked on the falling edge.
module tb_net_ingress_arbiter;

   localparam int NUM_PORTS = 4;
   localparam int PW        = $clog2(NUM_PORTS);

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   net_ingress_arbiter_if #(.NUM_PORTS(NUM_PORTS)) bus ();

   net_ingress_arbiter #(.NUM_PORTS(NUM_PORTS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [8:0] pq       [NUM_PORTS][$];
   logic [8:0] exp_q    [NUM_PORTS][$];
   bit         exp_ip_q [NUM_PORTS][$];
   int         exp_grant[$];

   logic [NUM_PORTS-1:0] hs = '0;
   int  stall_pct = 0;
   int  gap_pct   = 0;
   bit  check_gap = 0;
   bit  in_frame  = 0;
   int  cur_port  = 0;
   int  beat_idx  = 0;
   int  pulse_due = -1;
   int  last_end  = -1;

   // ---------------- driver: pops accepted bytes, presents the next ones ----------------
   initial begin
      logic [NUM_PORTS-1:0]   v, l;
      logic [8*NUM_PORTS-1:0] d;
      logic [8:0]             w;
      bus.IN_VALID  = '0;
      bus.IN_DATA   = '0;
      bus.IN_LAST   = '0;
      bus.OUT_READY = 1'b0;
      forever begin
         @(posedge CLK);
         cyc++;
         #1;
         v = '0; l = '0; d = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
            if (pq[p].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
               w          = pq[p][0];
               v[p]       = 1'b1;
               l[p]       = w[8];
               d[8*p +: 8] = w[7:0];
            end
         end
         bus.IN_VALID  = v;
         bus.IN_LAST   = l;
         bus.IN_DATA   = d;
         bus.OUT_READY = (int'($urandom_range(99)) >= stall_pct);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLK) begin
      logic [8:0]           got, want;
      logic [NUM_PORTS-1:0] mask;
      bit                   eip;
      int                   g;
      if (RST) begin
         hs = '0;
      end else begin
         hs   = bus.IN_VALID & bus.IN_READY;
         mask = NUM_PORTS'(1) << bus.OUT_PORT;
         n_assert++;
         if ((bus.IN_READY & ~mask) != '0) begin
            n_fail++;
            $display("FAIL in_ready_grant: IN_READY=%b with OUT_PORT=%0d, required only granted bit", bus.IN_READY, bus.OUT_PORT);
         end
         if (bus.IS_IP_VALID) begin
            n_assert++;
            if (pulse_due != cyc) begin
               n_fail++;
               $display("FAIL is_ip_valid_time: pulse at cycle %0d, required cycle %0d", cyc, pulse_due);
            end
            n_assert++;
            if (exp_ip_q[bus.OUT_PORT].size() == 0) begin
               n_fail++;
               $display("FAIL is_ip_extra: pulse on port %0d, required no pulse", bus.OUT_PORT);
            end else begin
               eip = exp_ip_q[bus.OUT_PORT].pop_front();
               if (bus.IS_IP !== eip) begin
                  n_fail++;
                  $display("FAIL is_ip: port %0d got %b, required %b", bus.OUT_PORT, bus.IS_IP, eip);
               end
            end
            pulse_due = -1;
         end else if (pulse_due >= 0 && cyc > pulse_due) begin
            n_assert++;
            n_fail++;
            $display("FAIL is_ip_valid_missing: no pulse by cycle %0d, required at cycle %0d", cyc, pulse_due);
            pulse_due = -1;
         end
         if (bus.OUT_VALID && bus.OUT_READY) begin
            if (!in_frame) begin
               in_frame = 1;
               cur_port = int'(bus.OUT_PORT);
               beat_idx = 0;
               if (exp_grant.size() > 0) begin
                  n_assert++;
                  g = exp_grant.pop_front();
                  if (int'(bus.OUT_PORT) != g) begin
                     n_fail++;
                     $display("FAIL grant_order: got port %0d, required port %0d", bus.OUT_PORT, g);
                  end
               end
               if (check_gap && last_end >= 0) begin
                  n_assert++;
                  if (cyc - last_end != 2) begin
                     n_fail++;
                     $display("FAIL frame_gap: %0d cycles between frames, required 2", cyc - last_end);
                  end
               end
            end else begin
               n_assert++;
               if (int'(bus.OUT_PORT) != cur_port) begin
                  n_fail++;
                  $display("FAIL grant_stable: OUT_PORT=%0d mid-frame, required %0d", bus.OUT_PORT, cur_port);
               end
            end
            got = {bus.OUT_LAST, bus.OUT_DATA};
            n_assert++;
            if (exp_q[bus.OUT_PORT].size() == 0) begin
               n_fail++;
               $display("FAIL byte_extra: port %0d got %h, required no byte", bus.OUT_PORT, got);
            end else begin
               want = exp_q[bus.OUT_PORT].pop_front();
               if (got !== want) begin
                  n_fail++;
                  $display("FAIL byte: port %0d idx %0d got {last,data}=%h, required %h", bus.OUT_PORT, beat_idx, got, want);
               end
            end
            if (beat_idx == 13 || (bus.OUT_LAST && beat_idx < 13)) pulse_due = cyc + 1;
            beat_idx++;
            if (bus.OUT_LAST) begin
               in_frame = 0;
               last_end = cyc;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic flush();
      for (int p = 0; p < NUM_PORTS; p++) begin
         pq[p].delete();
         exp_q[p].delete();
         exp_ip_q[p].delete();
      end
      exp_grant.delete();
      in_frame  = 0;
      pulse_due = -1;
      last_end  = -1;
      hs        = '0;
   endtask

   task automatic queue_frame(input int p, input int len, input logic [15:0] etype);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(255));
         if (i == 12) b = etype[15:8];
         if (i == 13) b = etype[7:0];
         pq[p].push_back({(i == len - 1), b});
         exp_q[p].push_back({(i == len - 1), b});
      end
      exp_ip_q[p].push_back(len >= 14 && etype == 16'h0800);
   endtask

   function automatic bit drained();
      for (int p = 0; p < NUM_PORTS; p++)
         if (pq[p].size() != 0 || exp_q[p].size() != 0 || exp_ip_q[p].size() != 0) return 0;
      return !in_frame && pulse_due < 0;
   endfunction

   task automatic wait_drain(input int budget, input string name);
      int  n    = 0;
      bit  done = 0;
      while (!done && n < budget) begin
         @(negedge CLK); #2;
         n++;
         done = drained();
      end
      n_assert++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_drain: not drained after %0d cycles, required all frames delivered", name, budget);
         flush();
      end
      n_assert++;
      if (exp_grant.size() != 0) begin
         n_fail++;
         $display("FAIL %s_grants: %0d expected grants unseen, required 0", name, exp_grant.size());
         exp_grant.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge CLK); #1;
      RST = 1'b1;
      flush();
      repeat (2) @(negedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      n_assert += 6;
      if (bus.IN_READY !== '0)   begin n_fail++; $display("FAIL %s_in_ready: got %b, required 0", name, bus.IN_READY); end
      if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL %s_out_valid: got %b, required 0", name, bus.OUT_VALID); end
      if (bus.OUT_LAST !== 1'b0)  begin n_fail++; $display("FAIL %s_out_last: got %b, required 0", name, bus.OUT_LAST); end
      if (bus.OUT_PORT !== '0)   begin n_fail++; $display("FAIL %s_out_port: got %0d, required 0", name, bus.OUT_PORT); end
      if (bus.IS_IP !== 1'b0)     begin n_fail++; $display("FAIL %s_is_ip: got %b, required 0", name, bus.IS_IP); end
      if (bus.IS_IP_VALID !== 1'b0) begin n_fail++; $display("FAIL %s_is_ip_valid: got %b, required 0", name, bus.IS_IP_VALID); end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      #1 RST = 1'b0;
   endtask

   task automatic test_single_ipv4();
      last_end = -1;
      exp_grant.push_back(0);
      queue_frame(0, 20, 16'h0800);
      wait_drain(200, "single_ipv4");
      repeat (3) @(negedge CLK);
      n_assert += 2;
      if (bus.IS_IP !== 1'b1) begin n_fail++; $display("FAIL is_ip_hold: got %b, required 1", bus.IS_IP); end
      if (bus.OUT_PORT !== 2'd0) begin n_fail++; $display("FAIL out_port_hold: got %0d, required 0", bus.OUT_PORT); end
   endtask

   task automatic test_round_robin();
      do_reset();
      check_gap = 1;
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < 3; p++) begin
            exp_grant.push_back(p);
            queue_frame(p, 15 + p + r, (r == 1) ? 16'h0800 : 16'h0806);
         end
      wait_drain(1000, "round_robin");
      check_gap = 0;
   endtask

   task automatic test_ipv6();
      last_end = -1;
      exp_grant.push_back(1);
      queue_frame(1, 60, 16'h86DD);
      wait_drain(300, "ipv6");
      n_assert++;
      if (bus.IS_IP !== 1'b0) begin n_fail++; $display("FAIL ipv6_is_ip: got %b, required 0", bus.IS_IP); end
   endtask

   task automatic test_back_to_back();
      last_end  = -1;
      check_gap = 1;
      exp_grant.push_back(3); queue_frame(3, 8,  16'h0800);
      exp_grant.push_back(3); queue_frame(3, 13, 16'h0800);
      exp_grant.push_back(3); queue_frame(3, 14, 16'h0800);
      wait_drain(300, "back_to_back");
      check_gap = 0;
   endtask

   task automatic test_random_stalls();
      last_end  = -1;
      stall_pct = 50;
      gap_pct   = 30;
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < NUM_PORTS; p++)
            queue_frame(p, int'($urandom_range(1, 40)),
                        ($urandom_range(1) == 1) ? 16'h0800 : 16'($urandom_range(16'hFFFF)));
      wait_drain(8000, "random_stalls");
      stall_pct = 0;
      gap_pct   = 0;
   endtask

   task automatic test_reset_mid_frame();
      int n = 0;
      last_end = -1;
      exp_grant.push_back(0);
      queue_frame(0, 16, 16'h0800);
      wait_drain(200, "pre_reset");
      exp_grant.push_back(2);
      queue_frame(2, 20, 16'h0800);
      while (!(in_frame && cur_port == 2 && beat_idx >= 5) && n < 200) begin
         @(negedge CLK); #1;
         n++;
      end
      n_assert++;
      if (n >= 200) begin n_fail++; $display("FAIL reset_mid_frame_start: port 2 frame not seen, required within 200 cycles"); end
      RST = 1'b1;
      flush();
      @(negedge CLK);
      check_reset_outputs("reset_mid_frame");
      #1 RST = 1'b0;
      exp_grant.push_back(0);
      exp_grant.push_back(2);
      queue_frame(0, 10, 16'h86DD);
      queue_frame(2, 10, 16'h86DD);
      wait_drain(300, "post_reset");
   endtask

   initial begin
      test_reset();
      test_single_ipv4();
      test_round_robin();
      test_ipv6();
      test_back_to_back();
      test_random_stalls();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
